// File: rtl/full_sum_seq_if.sv
// Handshake bundle between a vector producer, the full_sum_seq reducer and a stallable consumer.
// The master side drives vectors in and accepts results; the slave side is the reducer.
interface full_sum_seq_if #(
    parameter int NUM_INPUTS   = 4,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 32
);
    logic                                in_valid;
    logic                                in_ready;
    logic [NUM_INPUTS*INPUT_WIDTH-1:0]   INPUT;
    logic                                out_valid;
    logic                                out_ready;
    logic [OUTPUT_WIDTH-1:0]             SUM;
    logic                                OVF;

    modport master (
        output in_valid, INPUT, out_ready,
        input  in_ready, out_valid, SUM, OVF
    );

    modport slave (
        input  in_valid, INPUT, out_ready,
        output in_ready, out_valid, SUM, OVF
    );
endinterface

// File: rtl/full_sum_seq.sv
// Sequential multi-operand adder: captures a packed operand vector, reduces LANES operands
// per clock into a full-precision accumulator, then holds SUM/OVF until the consumer takes it.
module full_sum_seq #(
    parameter int NUM_INPUTS   = 4,
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 32,
    parameter int LANES        = 2,
    parameter int TC_MODE      = 0,
    parameter int SAT_MODE     = 0
) (
    input logic            clk,
    input logic            rst_n,
    full_sum_seq_if.slave  bus
);
    localparam int C  = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int AW = INPUT_WIDTH + $clog2(NUM_INPUTS) + 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    // One guard bit above whichever of AW/OUTPUT_WIDTH is wider keeps the range test uniform.
    localparam int WW = ((AW > OUTPUT_WIDTH) ? AW : OUTPUT_WIDTH) + 1;
    localparam logic [OUTPUT_WIDTH-1:0] SMIN = OUTPUT_WIDTH'(1) << (OUTPUT_WIDTH - 1);
    localparam logic [OUTPUT_WIDTH-1:0] SMAX = ~SMIN;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                              state_q, state_d;
    logic [NUM_INPUTS*INPUT_WIDTH-1:0]   ops_q, ops_d;
    logic [AW-1:0]                       acc_q, acc_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0]             sum_q, sum_d;
    logic                                ovf_q, ovf_d;
    logic                                out_valid_q, out_valid_d;
    logic                                in_ready_q, in_ready_d;

    logic [INPUT_WIDTH-1:0]  op_arr   [NUM_INPUTS];
    logic [AW-1:0]           lane_ext [LANES];
    logic [AW-1:0]           full_val;
    logic [WW-1:0]           fext;
    logic                    ovf_calc;
    logic [OUTPUT_WIDTH-1:0] sat_val;
    logic [OUTPUT_WIDTH-1:0] sum_calc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_op
            assign op_arr[gi] = ops_q[gi*INPUT_WIDTH +: INPUT_WIDTH];
        end

        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0]            idx;
            logic [INPUT_WIDTH-1:0] op;
            // Lane positions past the last operand select nothing and so contribute zero.
            always_comb begin
                idx = 32'(cnt_q) * 32'(LANES) + 32'(gi);
                op  = '0;
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (idx == 32'(k)) op = op_arr[k];
                end
            end
            assign lane_ext[gi] = (TC_MODE != 0)
                ? {{(AW-INPUT_WIDTH){op[INPUT_WIDTH-1]}}, op}
                : {{(AW-INPUT_WIDTH){1'b0}}, op};
        end
    endgenerate

    always_comb begin
        full_val = acc_q;
        for (int l = 0; l < LANES; l++) full_val = full_val + lane_ext[l];
    end

    always_comb begin
        fext = (TC_MODE != 0) ? {{(WW-AW){full_val[AW-1]}}, full_val}
                              : {{(WW-AW){1'b0}}, full_val};
        if (TC_MODE != 0) begin
            ovf_calc = !((&fext[WW-1:OUTPUT_WIDTH-1]) || !(|fext[WW-1:OUTPUT_WIDTH-1]));
            sat_val  = fext[WW-1] ? SMIN : SMAX;
        end else begin
            ovf_calc = |fext[WW-1:OUTPUT_WIDTH];
            sat_val  = '1;
        end
        sum_calc = ((SAT_MODE != 0) && ovf_calc) ? sat_val : fext[OUTPUT_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ops_d      = bus.INPUT;
                    acc_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = full_val;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(C - 1)) begin
                    sum_d       = sum_calc;
                    ovf_d       = ovf_calc;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ops_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.SUM       = sum_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_full_sum_seq.sv
// Scoreboard bench for full_sum_seq: five parameter variants share a clock and reset;
// stimulus pushes expected results, a negedge monitor pops them on each accepted output.
module tb_full_sum_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv   [5];
    logic [159:0] din  [5];
    logic         ordy [5];
    logic         ov   [5];
    logic         rdy  [5];
    logic         of   [5];
    logic [31:0]  sm   [5];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          inst;
        logic [31:0] sum;
        logic        ovf;
        string       nm;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    full_sum_seq_if #(.NUM_INPUTS(4), .INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) f0(), f1(), f2();
    full_sum_seq_if #(.NUM_INPUTS(5), .INPUT_WIDTH(32), .OUTPUT_WIDTH(32)) f3(), f4();

    assign f0.in_valid = iv[0]; assign f0.INPUT = din[0][127:0]; assign f0.out_ready = ordy[0];
    assign f1.in_valid = iv[1]; assign f1.INPUT = din[1][127:0]; assign f1.out_ready = ordy[1];
    assign f2.in_valid = iv[2]; assign f2.INPUT = din[2][127:0]; assign f2.out_ready = ordy[2];
    assign f3.in_valid = iv[3]; assign f3.INPUT = din[3];        assign f3.out_ready = ordy[3];
    assign f4.in_valid = iv[4]; assign f4.INPUT = din[4];        assign f4.out_ready = ordy[4];

    assign ov[0] = f0.out_valid; assign rdy[0] = f0.in_ready; assign sm[0] = f0.SUM; assign of[0] = f0.OVF;
    assign ov[1] = f1.out_valid; assign rdy[1] = f1.in_ready; assign sm[1] = f1.SUM; assign of[1] = f1.OVF;
    assign ov[2] = f2.out_valid; assign rdy[2] = f2.in_ready; assign sm[2] = f2.SUM; assign of[2] = f2.OVF;
    assign ov[3] = f3.out_valid; assign rdy[3] = f3.in_ready; assign sm[3] = f3.SUM; assign of[3] = f3.OVF;
    assign ov[4] = f4.out_valid; assign rdy[4] = f4.in_ready; assign sm[4] = f4.SUM; assign of[4] = f4.OVF;

    full_sum_seq u0 (.clk(clk), .rst_n(rst_n), .bus(f0));
    full_sum_seq #(.SAT_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
    full_sum_seq #(.TC_MODE(1), .SAT_MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(f2));
    full_sum_seq #(.NUM_INPUTS(5), .LANES(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(f3));
    full_sum_seq #(.NUM_INPUTS(5), .LANES(5)) u4 (.clk(clk), .rst_n(rst_n), .bus(f4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] v4(input logic [31:0] a0, a1, a2, a3);
        return {32'h0, a3, a2, a1, a0};
    endfunction

    function automatic logic [159:0] v5(input logic [31:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    // Monitor: every cycle where a result is presented and accepted consumes one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (ov[i] && ordy[i]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output inst %0d: got SUM=%0h, required no output", i, sm[i]);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk({e_mon.nm, "_inst"}, 64'(i), 64'(e_mon.inst));
                    chk({e_mon.nm, "_sum"}, 64'(sm[i]), 64'(e_mon.sum));
                    chk({e_mon.nm, "_ovf"}, 64'(of[i]), 64'(e_mon.ovf));
                    $display("txn %s inst=%0d SUM=%h OVF=%0d", e_mon.nm, i, sm[i], of[i]);
                end
            end
        end
    end

    task automatic wait_out(input int i, input string nm, input int lat);
        int n;
        n = 0;
        while (!ov[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        if (ordy[i]) begin
            n = 0;
            while (ov[i] && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk({nm, "_drained"}, 64'(ov[i]), 64'(0));
        end
    endtask

    task automatic send(input int i, input logic [159:0] v, input logic [31:0] es,
                        input logic eo, input int lat, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got in_ready=0 required 1", nm);
            return;
        end
        din[i] = v;
        iv[i]  = 1'b1;
        exp_q.push_back('{i, es, eo, nm});
        @(posedge clk); #1;
        iv[i] = 1'b0;
        chk({nm, "_in_ready_low"}, 64'(rdy[i]), 64'(0));
        wait_out(i, nm, lat);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            iv[i] = 1'b0; din[i] = '0; ordy[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(rdy[0]), 64'(1));
        chk("rst_out_valid", 64'(ov[0]), 64'(0));
        chk("rst_sum", 64'(sm[0]), 64'(0));
        chk("rst_ovf", 64'(of[0]), 64'(0));
        chk("rst_in_ready_n5", 64'(rdy[3]), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        send(0, v4(1, 2, 3, 4), 32'h0000000A, 1'b0, 2, "basic");
        send(0, v4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFC, 1'b1, 2, "u_wrap");
        send(1, v4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF, 1'b1, 2, "u_sat");
        send(2, v4(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd3, 32'd5), 32'h00000005, 1'b0, 2, "s_mixed");
        send(2, v4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 32'h7FFFFFFF, 1'b1, 2, "s_satmax");
        send(2, v4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 32'h80000000, 1'b1, 2, "s_satmin");
        send(3, v5(1, 2, 3, 4, 5), 32'd15, 1'b0, 3, "n5_l2");
        send(4, v5(1, 2, 3, 4, 5), 32'd15, 1'b0, 1, "n5_l5");

        // Back-pressure: result must hold while the consumer stalls; a waiting vector is held off.
        ordy[0] = 1'b0;
        send(0, v4(1, 1, 2, 2), 32'd6, 1'b0, 2, "bp");
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                din[0] = v4(10, 10, 10, 10);
                iv[0]  = 1'b1;
                exp_q.push_back('{0, 32'd40, 1'b0, "bp_next"});
            end
            @(posedge clk); #1;
            chk("bp_sum_stable", 64'(sm[0]), 64'(6));
            chk("bp_ovf_stable", 64'(of[0]), 64'(0));
            chk("bp_out_valid_held", 64'(ov[0]), 64'(1));
            chk("bp_in_ready_low", 64'(rdy[0]), 64'(0));
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 64'(ov[0]), 64'(0));
        chk("bp_release_in_ready", 64'(rdy[0]), 64'(1));
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp_next_captured", 64'(rdy[0]), 64'(0));
        wait_out(0, "bp_next", 2);

        // Reset in the middle of accumulation discards the partial sum without an output pulse.
        @(negedge clk);
        din[0] = v4(9, 9, 9, 9);
        iv[0]  = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(ov[0]), 64'(0));
        chk("arst_sum", 64'(sm[0]), 64'(0));
        chk("arst_ovf", 64'(of[0]), 64'(0));
        chk("arst_in_ready", 64'(rdy[0]), 64'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, v4(1, 1, 1, 1), 32'd4, 1'b0, 2, "post_rst");

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
